// File: rtl/nn_pkg.sv
// Shared types and constants for the neuron datapath: FSM state encoding and
// signed-range helpers used by the saturating adder.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ACC_W_DEF = 21;

  // Bit patterns of the largest / smallest w-bit signed values, in the low w bits.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return ~64'd0 << (w - 1);
  endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Term-input and result-output streams of the multiply-accumulate block.
interface mac_accumulator_if
  import nn_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = ACC_W_DEF
);
  // Handshake: a transfer happens on a rising clk edge where valid & ready are both 1.
  // While valid is 1 and ready is 0, the source holds its payload; the sink's ready
  // never depends combinationally on valid.
  logic                       in_valid;
  logic                       in_ready;
  logic signed [DATA_W-1:0]   data_in;
  logic signed [WEIGHT_W-1:0] weight_in;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [ACC_W-1:0]    data_out;
  logic                       overflow;

  modport master (
    output in_valid, data_in, weight_in, out_ready,
    input  in_ready, out_valid, data_out, overflow
  );

  modport slave (
    input  in_valid, data_in, weight_in, out_ready,
    output in_ready, out_valid, data_out, overflow
  );

endinterface

// File: rtl/mac_accumulator_sat_adder.sv
// Combinational signed W-bit adder with overflow detect; clamps to the signed
// range when SATURATE is set, otherwise wraps.
module sat_adder
  import nn_pkg::*;
#(
  parameter int W        = ACC_W_DEF,
  parameter bit SATURATE = 1'b1
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  localparam logic [63:0]        MAX64 = sat_max(W);
  localparam logic [63:0]        MIN64 = sat_min(W);
  localparam logic signed [W-1:0] MAX_V = MAX64[W-1:0];
  localparam logic signed [W-1:0] MIN_V = MIN64[W-1:0];

  logic [W:0] wide;

  assign wide = {a[W-1], a} + {b[W-1], b};

  // The two top bits of the W+1 bit sum disagree exactly when the result left W-bit range.
  always_comb begin
    ovf = wide[W] ^ wide[W-1];
    sum = wide[W-1:0];
    if (ovf && SATURATE) begin
      sum = wide[W] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Single-neuron signed multiply-accumulate: bias preload, num_terms accepted
// products summed one per cycle, result held until the consumer takes it.
module mac_accumulator
  import nn_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int WEIGHT_W  = 8,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_TERMS = 64,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic                               start,
  input  logic [$clog2(MAX_TERMS+1)-1:0]     num_terms,
  input  logic signed [ACC_W-1:0]            bias_in,
  output logic                               busy,
  output state_t                             dbg_state,
  mac_accumulator_if.slave                   io
);

  localparam int CNT_W  = $clog2(MAX_TERMS + 1);
  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          remaining_q, remaining_d;
  logic                      overflow_q, overflow_d;

  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   sum;
  logic                      sum_ovf;
  logic                      accept;
  logic [CNT_W-1:0]          n_eff;

  // Operands are sign-extended to the product width first so the multiply is full precision.
  assign prod     = PROD_W'(io.data_in) * PROD_W'(io.weight_in);
  assign prod_ext = ACC_W'(prod);
  assign accept   = (state_q == ACC) && io.in_valid;
  assign n_eff    = (num_terms > MAX_CNT) ? MAX_CNT : num_terms;

  sat_adder #(
    .W        (ACC_W),
    .SATURATE (SATURATE)
  ) u_sat_adder (
    .a   (acc_q),
    .b   (prod_ext),
    .sum (sum),
    .ovf (sum_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      overflow_q  <= overflow_d;
    end
  end

  // A start arriving with out_ready in DONE is dropped: DONE only ever returns to IDLE.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    overflow_d  = overflow_q;
    if (clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      remaining_d = '0;
      overflow_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_d       = bias_in;
            remaining_d = n_eff;
            overflow_d  = 1'b0;
            state_d     = (n_eff == '0) ? DONE : ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc_d       = sum;
            overflow_d  = overflow_q | sum_ovf;
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (io.out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    io.in_ready  = (state_q == ACC);
    io.out_valid = (state_q == DONE);
    io.data_out  = acc_q;
    io.overflow  = overflow_q;
    busy         = (state_q != IDLE);
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: a saturating and a wrapping instance share one stimulus
// stream; results are compared with vector tables and an integer reference model.
module tb_mac_accumulator;
  import nn_pkg::*;

  localparam int DATA_W    = 8;
  localparam int WEIGHT_W  = 8;
  localparam int ACC_W     = 21;
  localparam int MAX_TERMS = 64;
  localparam int CNT_W     = $clog2(MAX_TERMS + 1);
  localparam longint MAXV  = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint MINV  = -(longint'(1) <<< (ACC_W - 1));
  localparam longint MODV  = longint'(1) <<< ACC_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, clear, start;
  logic [CNT_W-1:0] num_terms;
  logic [ACC_W-1:0] bias_in;
  logic   busy_s, busy_w;
  state_t st_s, st_w;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_accumulator_if #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W)) if_s ();
  mac_accumulator_if #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W)) if_w ();

  assign if_w.in_valid  = if_s.in_valid;
  assign if_w.data_in   = if_s.data_in;
  assign if_w.weight_in = if_s.weight_in;
  assign if_w.out_ready = if_s.out_ready;

  mac_accumulator #(
    .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS), .SATURATE(1'b1)
  ) dut_sat (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .num_terms(num_terms),
    .bias_in(bias_in), .busy(busy_s), .dbg_state(st_s), .io(if_s)
  );

  mac_accumulator #(
    .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS), .SATURATE(1'b0)
  ) dut_wrap (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .num_terms(num_terms),
    .bias_in(bias_in), .busy(busy_w), .dbg_state(st_w), .io(if_w)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  int t_start = 0;
  int d_arr[128];
  int w_arr[128];
  logic [ACC_W-1:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: running sum in 64-bit integers, folded back into range after each term.
  function automatic longint model(input longint bias, input int n, input bit sat, output bit ovf);
    longint acc;
    int ne;
    acc = bias;
    ovf = 1'b0;
    ne  = (n > MAX_TERMS) ? MAX_TERMS : n;
    for (int i = 0; i < ne; i++) begin
      acc = acc + longint'(d_arr[i]) * longint'(w_arr[i]);
      if (acc > MAXV) begin
        ovf = 1'b1;
        acc = sat ? MAXV : acc - MODV;
      end else if (acc < MINV) begin
        ovf = 1'b1;
        acc = sat ? MINV : acc + MODV;
      end
    end
    return acc;
  endfunction

  // ---------------- drivers ----------------
  task automatic start_op(input longint bias, input int n);
    @(negedge clk);
    t_start        = cyc;
    start          = 1'b1;
    num_terms      = CNT_W'(n);
    bias_in        = ACC_W'(bias);
    if_s.in_valid  = 1'b1;
    if_s.data_in   = DATA_W'($urandom_range(0, 255));
    if_s.weight_in = WEIGHT_W'($urandom_range(0, 255));
    @(negedge clk);
    start         = 1'b0;
    if_s.in_valid = 1'b0;
  endtask

  task automatic feed(input int d, input int w, input int gap, input bit poke);
    int k;
    repeat (gap) begin
      if_s.in_valid = 1'b0;
      if (poke) begin
        start     = 1'b1;
        num_terms = CNT_W'($urandom_range(0, 5));
        bias_in   = ACC_W'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
    end
    if_s.in_valid  = 1'b1;
    if_s.data_in   = DATA_W'(d);
    if_s.weight_in = WEIGHT_W'(w);
    k = 0;
    while (!if_s.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) check("in_ready_timeout", 0, 1);
    @(negedge clk);
    if_s.in_valid = 1'b0;
  endtask

  task automatic finish_op(input longint es, input bit os, input longint ew, input bit ow,
                           input int stall, input bit poke, input bit chk_cyc, input int n_eff,
                           input string tag);
    int bad;
    int k;
    check({tag, "_out_valid_latency"}, longint'(if_s.out_valid), 1);
    k = 0;
    while (!if_s.out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k == 100) check({tag, "_out_valid_timeout"}, 0, 1);
    exp_q.push_back(ACC_W'(es));
    bad = 0;
    repeat (stall) begin
      if_s.in_valid  = 1'b1;
      if_s.data_in   = DATA_W'($urandom_range(0, 255));
      if_s.weight_in = WEIGHT_W'($urandom_range(0, 255));
      if (poke) begin
        start     = 1'b1;
        num_terms = CNT_W'($urandom_range(1, 5));
        bias_in   = ACC_W'($urandom);
      end
      if (!if_s.out_valid || longint'(if_s.data_out) != es || if_s.overflow != os) bad++;
      @(negedge clk);
    end
    if (stall > 0) check({tag, "_hold_stable"}, bad, 0);
    check({tag, "_sat_data"}, longint'(if_s.data_out), longint'($signed(exp_q.pop_front())));
    check({tag, "_sat_ovf"}, longint'(if_s.overflow), longint'(os));
    check({tag, "_wrap_data"}, longint'(if_w.data_out), ew);
    check({tag, "_wrap_ovf"}, longint'(if_w.overflow), longint'(ow));
    if_s.in_valid  = 1'b0;
    if_s.out_ready = 1'b1;
    start          = poke;
    num_terms      = CNT_W'(1);
    @(negedge clk);
    start          = 1'b0;
    if_s.out_ready = 1'b0;
    check({tag, "_release_valid"}, longint'(if_s.out_valid), 0);
    check({tag, "_release_idle"}, longint'(busy_s), 0);
    if (chk_cyc) check({tag, "_occupancy"}, cyc - t_start, n_eff + 2);
  endtask

  task automatic do_op(input longint bias, input int n, input int gap_max, input int stall,
                       input bit poke, input bit chk_cyc, input longint es, input bit os,
                       input longint ew, input bit ow, input string tag);
    int ne;
    ne = (n > MAX_TERMS) ? MAX_TERMS : n;
    start_op(bias, n);
    for (int i = 0; i < ne; i++) feed(d_arr[i], w_arr[i], $urandom_range(0, gap_max), poke);
    finish_op(es, os, ew, ow, stall, poke, chk_cyc, ne, tag);
  endtask

  task automatic model_op(input longint bias, input int n, input int gap_max, input int stall,
                          input bit poke, input bit chk_cyc, input string tag);
    longint es, ew;
    bit os, ow;
    es = model(bias, n, 1'b1, os);
    ew = model(bias, n, 1'b0, ow);
    do_op(bias, n, gap_max, stall, poke, chk_cyc, es, os, ew, ow, tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    longint bias;
    int     n;
    int     d0, d1, d2;
    int     w0, w1, w2;
    longint exp_s;
    bit     ovf_s;
    longint exp_w;
    bit     ovf_w;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    longint bias;
    int n;
    int mode;
    int bad;

    vecs[0] = '{5, 3, 2, -4, 7, 3, 1, -2, -7, 1'b0, -7, 1'b0};
    vecs[1] = '{1048570, 1, 10, 0, 0, 10, 0, 0, 1048575, 1'b1, -1048482, 1'b1};
    vecs[2] = '{-1048570, 1, -10, 0, 0, 10, 0, 0, -1048576, 1'b1, 1048482, 1'b1};
    vecs[3] = '{1234, 0, 0, 0, 0, 0, 0, 0, 1234, 1'b0, 1234, 1'b0};
    vecs[4] = '{1048570, 2, 10, -10, 0, 10, 10, 0, 1048475, 1'b1, 1048570, 1'b1};
    vecs[5] = '{1048569, 1, 2, 0, 0, 3, 0, 0, 1048575, 1'b0, 1048575, 1'b0};
    vecs[6] = '{0, 2, -128, -128, 0, -128, 127, 0, 128, 1'b0, 128, 1'b0};
    vecs[7] = '{-1048576, 1, -128, 0, 0, -128, 0, 0, -1032192, 1'b0, -1032192, 1'b0};
    vecs[8] = '{-1048575, 1, 1, 0, 0, -1, 0, 0, -1048576, 1'b0, -1048576, 1'b0};

    rst = 1'b1; clear = 1'b0; start = 1'b0; num_terms = '0; bias_in = '0;
    if_s.in_valid = 1'b0; if_s.data_in = '0; if_s.weight_in = '0; if_s.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", longint'(busy_s), 0);
    check("reset_in_ready", longint'(if_s.in_ready), 0);
    check("reset_out_valid", longint'(if_s.out_valid), 0);
    check("reset_data", longint'(if_s.data_out), 0);
    check("reset_ovf", longint'(if_s.overflow), 0);

    // Table vectors, first one with no gaps/stall to pin exact timing.
    for (int v = 0; v < 9; v++) begin
      d_arr[0] = vecs[v].d0; d_arr[1] = vecs[v].d1; d_arr[2] = vecs[v].d2;
      w_arr[0] = vecs[v].w0; w_arr[1] = vecs[v].w1; w_arr[2] = vecs[v].w2;
      do_op(vecs[v].bias, vecs[v].n, (v == 0) ? 0 : 2, (v == 0) ? 0 : $urandom_range(0, 3),
            v != 0, v == 0, vecs[v].exp_s, vecs[v].ovf_s, vecs[v].exp_w, vecs[v].ovf_w,
            $sformatf("vec%0d", v));
    end

    // Long backpressure with start pokes during ACC and DONE.
    d_arr[0] = 100; w_arr[0] = -3; d_arr[1] = 5; w_arr[1] = 9;
    do_op(17, 2, 3, 10, 1'b1, 1'b0, -238, 1'b0, -238, 1'b0, "stall10");

    // Abort after 2 of 5 terms.
    start_op(100, 5);
    feed(3, 4, 0, 1'b0);
    feed(-7, 2, 1, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_busy", longint'(busy_s), 0);
    check("clear_out_valid", longint'(if_s.out_valid), 0);
    check("clear_data", longint'(if_s.data_out), 0);
    bad = 0;
    repeat (5) begin
      if_s.in_valid = 1'b1;
      if (if_s.out_valid || if_w.out_valid || busy_s) bad++;
      @(negedge clk);
    end
    if_s.in_valid = 1'b0;
    check("clear_no_result", bad, 0);
    d_arr[0] = 3; w_arr[0] = 3;
    do_op(0, 1, 0, 0, 1'b0, 1'b1, 9, 1'b0, 9, 1'b0, "after_clear");

    // Reset while a saturated result waits in DONE.
    start_op(1048570, 1);
    feed(10, 10, 0, 1'b0);
    check("pre_rst_ovf", longint'(if_s.overflow), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_done_busy", longint'(busy_s), 0);
    check("rst_done_in_ready", longint'(if_s.in_ready), 0);
    check("rst_done_out_valid", longint'(if_s.out_valid), 0);
    check("rst_done_data", longint'(if_s.data_out), 0);
    check("rst_done_ovf", longint'(if_s.overflow), 0);
    check("rst_done_state", longint'(st_s), longint'(IDLE));

    // Randomized operations against the reference model.
    for (int r = 0; r < 16; r++) begin
      n    = (r % 5 == 4) ? $urandom_range(65, 127) : $urandom_range(0, 9);
      mode = $urandom_range(0, 2);
      if (mode == 0) bias = MAXV - longint'($urandom_range(0, 40000));
      else if (mode == 1) bias = MINV + longint'($urandom_range(0, 40000));
      else bias = longint'($urandom_range(0, 20000)) - 10000;
      for (int i = 0; i < 128; i++) begin
        d_arr[i] = int'($urandom_range(0, 255)) - 128;
        w_arr[i] = int'($urandom_range(0, 255)) - 128;
      end
      model_op(bias, n, 2, $urandom_range(0, 4), 1'b1, 1'b0, $sformatf("rand%0d", r));
    end

    // Back-to-back full-length operations of maximal positive products.
    for (int i = 0; i < MAX_TERMS; i++) begin
      d_arr[i] = 127;
      w_arr[i] = 127;
    end
    for (int b = 0; b < 4; b++) begin
      bias = longint'($urandom_range(0, 20000));
      model_op(bias, MAX_TERMS, 0, 0, 1'b0, 1'b1, $sformatf("b2b%0d", b));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
